// File: rtl/rvga_types_pkg.sv
// Shared pipeline types: the memory-stage control word and the encodings the
// writeback stage depends on.
package rvga_types;

   localparam int rvga_pc_width_gp       = 32;
   localparam int rvga_reg_addr_width_gp = 5;
   localparam int rvga_word_width_gp     = 32;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } rvga_load_funct3;

   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      LOAD_WAIT = 1'b1
   } rvga_wb_state;

   typedef struct packed {
      logic [rvga_pc_width_gp-1:0]       pc;
      logic [rvga_reg_addr_width_gp-1:0] rd;
      logic                              rd_w_v;
      logic                              dmem_r_v;
      logic [2:0]                        funct3;
      logic [1:0]                        addr_lo;
      logic [rvga_word_width_gp-1:0]     result;
   } rvga_memory_cword;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Selects the addressed byte/halfword of a raw data-memory word and sign- or
// zero-extends it according to the load funct3.
module load_align
   import rvga_types::*;
#(
   parameter int word_width_p = 32
) (
   input  logic [2:0]              funct3_i,
   input  logic [1:0]              addr_lo_i,
   input  logic [word_width_p-1:0] raw_i,
   output logic [word_width_p-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = raw_i[{addr_lo_i, 3'b000} +: 8];
      // Halfword loads ignore the low address bit.
      half_sel = raw_i[{addr_lo_i[1], 4'b0000} +: 16];
      data_o   = raw_i;
      case (funct3_i)
         LB:      data_o = {{(word_width_p-8){byte_sel[7]}}, byte_sel};
         LBU:     data_o = {{(word_width_p-8){1'b0}}, byte_sel};
         LH:      data_o = {{(word_width_p-16){half_sel[15]}}, half_sel};
         LHU:     data_o = {{(word_width_p-16){1'b0}}, half_sel};
         default: data_o = raw_i;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires control words onto the register-file write
// port, waits for load data when needed, counts retirements, flags timeouts.
module writeback_stage
   import rvga_types::*;
#(
   parameter int word_width_p    = 32,
   parameter int timeout_p       = 255,
   parameter int instret_width_p = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       cword_v_i,
   input  rvga_memory_cword           cword_i,
   input  logic                       dmem_resp_v_i,
   input  logic [word_width_p-1:0]    dmem_resp_data_i,
   output logic                       stall_v_o,
   output logic [4:0]                 rd_o,
   output logic [word_width_p-1:0]    rd_data_o,
   output logic                       rd_w_v_o,
   output logic [instret_width_p-1:0] instret_o,
   output logic                       dmem_err_o
);

   localparam int cnt_width_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
   localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(timeout_p - 1);

   rvga_wb_state                state_q,   state_d;
   rvga_memory_cword            hold_q,    hold_d;
   logic [cnt_width_lp-1:0]     cnt_q,     cnt_d;
   logic [4:0]                  rd_q,      rd_d;
   logic [word_width_p-1:0]     rd_data_q, rd_data_d;
   logic                        rd_w_v_q,  rd_w_v_d;
   logic [instret_width_p-1:0]  instret_q, instret_d;
   logic                        err_q,     err_d;

   rvga_memory_cword            sel_cword;
   logic [word_width_p-1:0]     aligned_data;
   logic                        retire_v;

   // The aligner sees the held load while waiting, otherwise the incoming word.
   assign sel_cword = (state_q == LOAD_WAIT) ? hold_q : cword_i;

   load_align #(
      .word_width_p(word_width_p)
   ) u_load_align (
      .funct3_i (sel_cword.funct3),
      .addr_lo_i(sel_cword.addr_lo),
      .raw_i    (dmem_resp_data_i),
      .data_o   (aligned_data)
   );

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      cnt_d     = cnt_q;
      rd_d      = rd_q;
      rd_data_d = rd_data_q;
      rd_w_v_d  = 1'b0;
      instret_d = instret_q;
      err_d     = err_q;
      retire_v  = 1'b0;

      case (state_q)
         IDLE: begin
            if (cword_v_i) begin
               if (!cword_i.dmem_r_v || dmem_resp_v_i) begin
                  retire_v = 1'b1;
               end else begin
                  hold_d  = cword_i;
                  cnt_d   = '0;
                  state_d = LOAD_WAIT;
               end
            end
         end
         LOAD_WAIT: begin
            if (dmem_resp_v_i) begin
               retire_v = 1'b1;
               state_d  = IDLE;
            end else if (cnt_q == cnt_last_lp) begin
               // Abandon the load: no write and it does not count as retired.
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + cnt_width_lp'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (retire_v) begin
         instret_d = instret_q + instret_width_p'(1);
         if (sel_cword.rd_w_v && (sel_cword.rd != 5'd0)) begin
            rd_w_v_d  = 1'b1;
            rd_d      = sel_cword.rd;
            rd_data_d = sel_cword.dmem_r_v ? aligned_data
                                           : word_width_p'(sel_cword.result);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         cnt_q     <= '0;
         rd_q      <= '0;
         rd_data_q <= '0;
         rd_w_v_q  <= 1'b0;
         instret_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         cnt_q     <= cnt_d;
         rd_q      <= rd_d;
         rd_data_q <= rd_data_d;
         rd_w_v_q  <= rd_w_v_d;
         instret_q <= instret_d;
         err_q     <= err_d;
      end
   end

   assign stall_v_o  = (state_q == LOAD_WAIT);
   assign rd_o       = rd_q;
   assign rd_data_o  = rd_data_q;
   assign rd_w_v_o   = rd_w_v_q;
   assign instret_o  = instret_q;
   assign dmem_err_o = err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: expected register writes go into a
// scoreboard queue that a negedge monitor drains; status outputs are checked inline.
module tb_writeback_stage;
   import rvga_types::*;

   localparam int word_width_p    = 32;
   localparam int timeout_p       = 4;
   localparam int instret_width_p = 64;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_exp_t;

   logic                       clk_i = 1'b0;
   logic                       rst_i = 1'b1;
   logic                       cword_v_i = 1'b0;
   rvga_memory_cword           cword_i = '0;
   logic                       dmem_resp_v_i = 1'b0;
   logic [word_width_p-1:0]    dmem_resp_data_i = '0;
   logic                       stall_v_o;
   logic [4:0]                 rd_o;
   logic [word_width_p-1:0]    rd_data_o;
   logic                       rd_w_v_o;
   logic [instret_width_p-1:0] instret_o;
   logic                       dmem_err_o;

   wb_exp_t exp_q[$];
   int      n_vec = 0;
   int      n_bad = 0;

   writeback_stage #(
      .word_width_p   (word_width_p),
      .timeout_p      (timeout_p),
      .instret_width_p(instret_width_p)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .cword_v_i       (cword_v_i),
      .cword_i         (cword_i),
      .dmem_resp_v_i   (dmem_resp_v_i),
      .dmem_resp_data_i(dmem_resp_data_i),
      .stall_v_o       (stall_v_o),
      .rd_o            (rd_o),
      .rd_data_o       (rd_data_o),
      .rd_w_v_o        (rd_w_v_o),
      .instret_o       (instret_o),
      .dmem_err_o      (dmem_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Monitor: every register write must match the head of the scoreboard.
   always @(negedge clk_i) begin
      if (rd_w_v_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_write: got rd=%0d data=0x%08h expected no write", rd_o, rd_data_o);
         end else begin
            wb_exp_t e;
            e = exp_q.pop_front();
            check("wb_rd", 64'(rd_o), 64'(e.rd));
            check("wb_data", 64'(rd_data_o), 64'(e.data));
         end
      end
   end

   function automatic rvga_memory_cword mk(input logic [4:0] rd, input logic w,
                                           input logic ld, input logic [2:0] f3,
                                           input logic [1:0] alo, input logic [31:0] res);
      rvga_memory_cword c;
      c          = '0;
      c.pc       = 32'h0000_1000;
      c.rd       = rd;
      c.rd_w_v   = w;
      c.dmem_r_v = ld;
      c.funct3   = f3;
      c.addr_lo  = alo;
      c.result   = res;
      return c;
   endfunction

   // Load accepted with no response; data arrives in the third stall cycle.
   task automatic delayed_load(input string name, input logic [2:0] f3, input logic [1:0] alo,
                               input logic [4:0] rd, input logic [31:0] word,
                               input logic [31:0] exp_data, input logic [63:0] exp_instret);
      wb_exp_t e;
      cword_i   = mk(rd, 1'b1, 1'b1, f3, alo, 32'hDEAD_BEEF);
      cword_v_i = 1'b1;
      tick();
      cword_v_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check({name, "_stall"}, 64'(stall_v_o), 64'd1);
         if (i < 2) tick();
      end
      dmem_resp_v_i    = 1'b1;
      dmem_resp_data_i = word;
      e.rd = rd; e.data = exp_data;
      exp_q.push_back(e);
      tick();
      dmem_resp_v_i = 1'b0;
      check({name, "_stall_drop"}, 64'(stall_v_o), 64'd0);
      check({name, "_wv"}, 64'(rd_w_v_o), 64'd1);
      check({name, "_instret"}, instret_o, exp_instret);
   endtask

   initial begin
      wb_exp_t e;
      #12;
      check("rst_stall", 64'(stall_v_o), 64'd0);
      check("rst_wv", 64'(rd_w_v_o), 64'd0);
      check("rst_rd", 64'(rd_o), 64'd0);
      check("rst_data", 64'(rd_data_o), 64'd0);
      check("rst_instret", instret_o, 64'd0);
      check("rst_err", 64'(dmem_err_o), 64'd0);
      tick();
      rst_i = 1'b0;

      // ALU retire
      cword_i = mk(5'd5, 1'b1, 1'b0, 3'b000, 2'd0, 32'h1234_5678);
      cword_v_i = 1'b1;
      e.rd = 5'd5; e.data = 32'h1234_5678;
      exp_q.push_back(e);
      tick();
      cword_v_i = 1'b0;
      check("alu_wv", 64'(rd_w_v_o), 64'd1);
      check("alu_instret", instret_o, 64'd1);
      check("alu_stall", 64'(stall_v_o), 64'd0);

      // x0 suppression
      cword_i = mk(5'd0, 1'b1, 1'b0, 3'b000, 2'd0, 32'hFFFF_FFFF);
      cword_v_i = 1'b1;
      tick();
      cword_v_i = 1'b0;
      check("x0_wv", 64'(rd_w_v_o), 64'd0);
      check("x0_instret", instret_o, 64'd2);

      delayed_load("lb",  3'b000, 2'd2, 5'd7,  32'h0080_0000, 32'hFFFF_FF80, 64'd3);
      delayed_load("lbu", 3'b100, 2'd2, 5'd8,  32'h0080_0000, 32'h0000_0080, 64'd4);
      delayed_load("lhu", 3'b101, 2'd3, 5'd10, 32'h0080_0000, 32'h0000_0080, 64'd5);
      delayed_load("lw",  3'b010, 2'd1, 5'd11, 32'h8765_4321, 32'h8765_4321, 64'd6);

      // Same-cycle load response
      cword_i = mk(5'd9, 1'b1, 1'b1, 3'b001, 2'd0, 32'h0);
      cword_v_i = 1'b1;
      dmem_resp_v_i = 1'b1;
      dmem_resp_data_i = 32'h0000_8001;
      e.rd = 5'd9; e.data = 32'hFFFF_8001;
      exp_q.push_back(e);
      tick();
      cword_v_i = 1'b0;
      dmem_resp_v_i = 1'b0;
      check("lh_now_stall", 64'(stall_v_o), 64'd0);
      check("lh_now_wv", 64'(rd_w_v_o), 64'd1);
      check("lh_now_instret", instret_o, 64'd7);

      // Timeout
      cword_i = mk(5'd12, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0);
      cword_v_i = 1'b1;
      tick();
      cword_v_i = 1'b0;
      for (int i = 0; i < timeout_p; i++) begin
         check("to_stall", 64'(stall_v_o), 64'd1);
         check("to_err_low", 64'(dmem_err_o), 64'd0);
         tick();
      end
      check("to_stall_drop", 64'(stall_v_o), 64'd0);
      check("to_err", 64'(dmem_err_o), 64'd1);
      check("to_wv", 64'(rd_w_v_o), 64'd0);
      check("to_instret", instret_o, 64'd7);
      cword_i = mk(5'd3, 1'b1, 1'b0, 3'b000, 2'd0, 32'hCAFE_BABE);
      cword_v_i = 1'b1;
      e.rd = 5'd3; e.data = 32'hCAFE_BABE;
      exp_q.push_back(e);
      tick();
      cword_v_i = 1'b0;
      check("post_to_wv", 64'(rd_w_v_o), 64'd1);
      check("post_to_instret", instret_o, 64'd8);
      check("err_sticky", 64'(dmem_err_o), 64'd1);

      // Async reset in LOAD_WAIT
      cword_i = mk(5'd14, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0);
      cword_v_i = 1'b1;
      tick();
      cword_v_i = 1'b0;
      check("ar_stall_before", 64'(stall_v_o), 64'd1);
      #2 rst_i = 1'b1;
      #1;
      check("ar_stall", 64'(stall_v_o), 64'd0);
      check("ar_instret", instret_o, 64'd0);
      check("ar_err", 64'(dmem_err_o), 64'd0);
      check("ar_rd", 64'(rd_o), 64'd0);
      check("ar_data", 64'(rd_data_o), 64'd0);
      tick();
      rst_i = 1'b0;
      dmem_resp_v_i = 1'b1;
      dmem_resp_data_i = 32'h5555_AAAA;
      tick();
      dmem_resp_v_i = 1'b0;
      check("ar_late_wv", 64'(rd_w_v_o), 64'd0);
      check("ar_late_instret", instret_o, 64'd0);
      tick();
      tick();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
